// File: rtl/sw_pe_cfg.sv
`default_nettype none
// ============================================================================
// Module   : sw_pe_cfg
// Purpose  : One query-symbol cell of a Smith-Waterman systolic array with
//            affine gaps. Scoring constants arrive on runtime ports, every
//            add saturates, and all score compares are signed.
//            Optional feature macro: SW_PE_MAX_TRACK_EN. When it is defined,
//            the cell also records the best V seen this pass and the
//            active-cycle index where it occurred. When it is undefined,
//            max_out and max_pos_out are tied to 0.
// Ports    : clk, rst (sync, active-high), stall (freeze all state)
//            cfg_match/cfg_mismatch/cfg_gap_open/cfg_gap_ext : signed scores
//            V_in, F_in, T_in, S_in, store_S_in, init_in     : upstream chain
//            init_V, init_E                                  : inactive loads
//            V_out, E_out, F_out, T_out, S_out,
//            store_S_out, init_out                           : downstream chain
//            max_out, max_pos_out                            : pass best score
// Revision : 1.0  initial release
// ============================================================================
module sw_pe_cfg #(
  parameter int WIDTH = 12,
  parameter int SYM_W = 2,
  parameter int POS_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic signed [WIDTH-1:0] cfg_match,
  input  logic signed [WIDTH-1:0] cfg_mismatch,
  input  logic signed [WIDTH-1:0] cfg_gap_open,
  input  logic signed [WIDTH-1:0] cfg_gap_ext,
  input  logic signed [WIDTH-1:0] V_in,
  input  logic signed [WIDTH-1:0] F_in,
  input  logic        [SYM_W-1:0] T_in,
  input  logic        [SYM_W-1:0] S_in,
  input  logic                    store_S_in,
  input  logic                    init_in,
  input  logic signed [WIDTH-1:0] init_V,
  input  logic signed [WIDTH-1:0] init_E,
  output logic signed [WIDTH-1:0] V_out,
  output logic signed [WIDTH-1:0] E_out,
  output logic signed [WIDTH-1:0] F_out,
  output logic        [SYM_W-1:0] T_out,
  output logic        [SYM_W-1:0] S_out,
  output logic                    store_S_out,
  output logic                    init_out,
  output logic signed [WIDTH-1:0] max_out,
  output logic        [POS_W-1:0] max_pos_out
);

  localparam logic signed [WIDTH-1:0] C_SCORE_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] C_SCORE_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Sum in WIDTH+1 bits; the two top bits disagree only on overflow, and the
  // top bit then gives the true sign, so it selects the clamp direction.
  function automatic logic signed [WIDTH-1:0] sat_add(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1])
      sat_add = s[WIDTH] ? C_SCORE_MIN : C_SCORE_MAX;
    else
      sat_add = s[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] smax(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    smax = (a > b) ? a : b;
  endfunction

  logic signed [WIDTH-1:0] r_v, r_e, r_f, r_v_diag;
  logic        [SYM_W-1:0] r_t, r_s;
  logic                    r_store_s, r_init;

  logic signed [WIDTH-1:0] w_new_e, w_new_f, w_m, w_new_v;

  always_comb begin
    w_new_e = smax(sat_add(r_v, cfg_gap_open), sat_add(r_e, cfg_gap_ext));
    w_new_f = smax(sat_add(V_in, cfg_gap_open), sat_add(F_in, cfg_gap_ext));
    w_m     = sat_add(r_v_diag, (r_s == T_in) ? cfg_match : cfg_mismatch);
    // Local alignment: the score floors at zero.
    w_new_v = smax(smax('0, w_new_e), smax(w_new_f, w_m));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v       <= '0;
      r_e       <= '0;
      r_f       <= '0;
      r_v_diag  <= '0;
      r_t       <= '0;
      r_s       <= '0;
      r_store_s <= 1'b0;
      r_init    <= 1'b0;
    end else if (!stall) begin
      r_t       <= T_in;
      r_init    <= init_in;
      r_store_s <= store_S_in;
      r_v_diag  <= V_in;
      if (store_S_in)
        r_s <= S_in;
      if (init_in) begin
        r_v <= w_new_v;
        r_e <= w_new_e;
        r_f <= w_new_f;
      end else begin
        // While inactive the controller preloads V/E; F keeps its value.
        r_v <= init_V;
        r_e <= init_E;
      end
    end
  end

  assign V_out       = r_v;
  assign E_out       = r_e;
  assign F_out       = r_f;
  assign T_out       = r_t;
  assign S_out       = r_s;
  assign store_S_out = r_store_s;
  assign init_out    = r_init;

`ifdef SW_PE_MAX_TRACK_EN
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                  r_state;
  logic        [POS_W-1:0] r_pos, r_max_pos;
  logic signed [WIDTH-1:0] r_max;

  // r_state mirrors the registered init: ACTIVE for every cycle after the
  // first active cycle of a pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pos     <= '0;
      r_max     <= '0;
      r_max_pos <= '0;
    end else if (!stall) begin
      case (r_state)
        IDLE: begin
          if (init_in) begin
            r_state   <= ACTIVE;
            r_pos     <= '0;
            r_max     <= w_new_v;
            r_max_pos <= '0;
          end
        end
        ACTIVE: begin
          if (init_in) begin
            r_pos <= r_pos + 1'b1;
            // Strict compare keeps the earliest position on ties.
            if (w_new_v > r_max) begin
              r_max     <= w_new_v;
              r_max_pos <= r_pos + 1'b1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign max_out     = r_max;
  assign max_pos_out = r_max_pos;
`else
  assign max_out     = '0;
  assign max_pos_out = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sw_pe_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_pe_cfg
// Purpose  : Self-checking bench for sw_pe_cfg. An integer reference model
//            tracks the cell state and is compared against every output on
//            each falling edge; directed literal checks pin the model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sw_pe_cfg;

  localparam int WIDTH = 12;
  localparam int SYM_W = 2;
  localparam int POS_W = 16;
  localparam int SMAX  = (1 << (WIDTH-1)) - 1;
  localparam int SMIN  = -(1 << (WIDTH-1));
`ifdef SW_PE_MAX_TRACK_EN
  localparam bit MT = 1'b1;
`else
  localparam bit MT = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst, stall;
  logic signed [WIDTH-1:0] cfg_match, cfg_mismatch, cfg_gap_open, cfg_gap_ext;
  logic signed [WIDTH-1:0] V_in, F_in, init_V, init_E;
  logic        [SYM_W-1:0] T_in, S_in;
  logic                    store_S_in, init_in;
  logic signed [WIDTH-1:0] V_out, E_out, F_out, max_out;
  logic        [SYM_W-1:0] T_out, S_out;
  logic                    store_S_out, init_out;
  logic        [POS_W-1:0] max_pos_out;

  sw_pe_cfg #(.WIDTH(WIDTH), .SYM_W(SYM_W), .POS_W(POS_W)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .cfg_match(cfg_match), .cfg_mismatch(cfg_mismatch),
    .cfg_gap_open(cfg_gap_open), .cfg_gap_ext(cfg_gap_ext),
    .V_in(V_in), .F_in(F_in), .T_in(T_in), .S_in(S_in),
    .store_S_in(store_S_in), .init_in(init_in),
    .init_V(init_V), .init_E(init_E),
    .V_out(V_out), .E_out(E_out), .F_out(F_out),
    .T_out(T_out), .S_out(S_out),
    .store_S_out(store_S_out), .init_out(init_out),
    .max_out(max_out), .max_pos_out(max_pos_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (plain integers) ----------------
  function automatic int clamp_add(input int a, input int b);
    int s = a + b;
    if (s > SMAX) return SMAX;
    if (s < SMIN) return SMIN;
    return s;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  int m_v = 0, m_e = 0, m_f = 0, m_vd = 0, m_t = 0, m_s = 0, m_st = 0, m_init = 0;
  int m_max = 0, m_maxpos = 0, m_pos = 0;

  always @(posedge clk) begin
    int ne, nf, mm, nv;
    if (rst) begin
      m_v = 0; m_e = 0; m_f = 0; m_vd = 0; m_t = 0; m_s = 0; m_st = 0; m_init = 0;
      m_max = 0; m_maxpos = 0; m_pos = 0;
    end else if (!stall) begin
      ne = imax(clamp_add(m_v, int'(cfg_gap_open)), clamp_add(m_e, int'(cfg_gap_ext)));
      nf = imax(clamp_add(int'(V_in), int'(cfg_gap_open)), clamp_add(int'(F_in), int'(cfg_gap_ext)));
      mm = clamp_add(m_vd, (m_s == int'(T_in)) ? int'(cfg_match) : int'(cfg_mismatch));
      nv = imax(imax(0, ne), imax(nf, mm));
      if (MT && init_in) begin
        if (m_init == 0) begin
          m_pos = 0; m_max = nv; m_maxpos = 0;
        end else begin
          m_pos = (m_pos + 1) % (1 << POS_W);
          if (nv > m_max) begin
            m_max = nv; m_maxpos = m_pos;
          end
        end
      end
      if (init_in) begin
        m_v = nv; m_e = ne; m_f = nf;
      end else begin
        m_v = int'(init_V); m_e = int'(init_E);
      end
      m_t = int'(T_in); m_init = int'(init_in); m_st = int'(store_S_in); m_vd = int'(V_in);
      if (store_S_in) m_s = int'(S_in);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("V_out", int'(V_out), m_v);
      check("E_out", int'(E_out), m_e);
      check("F_out", int'(F_out), m_f);
      check("T_out", int'(T_out), m_t);
      check("S_out", int'(S_out), m_s);
      check("store_S_out", int'(store_S_out), m_st);
      check("init_out", int'(init_out), m_init);
      check("max_out", int'(max_out), m_max);
      check("max_pos_out", int'(max_pos_out), m_maxpos);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; stall = 1'b1;
    cfg_match = 12'sd2; cfg_mismatch = -12'sd2; cfg_gap_open = -12'sd2; cfg_gap_ext = -12'sd1;
    V_in = 12'sd5; F_in = 12'sd9; init_V = 12'sd4; init_E = 12'sd4;
    T_in = 2'd3; S_in = 2'd3; store_S_in = 1'b1; init_in = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc();
    check("rst_V", int'(V_out), 0);
    check("rst_E", int'(E_out), 0);
    check("rst_T", int'(T_out), 0);
    check("rst_init", int'(init_out), 0);
    check("rst_max", int'(max_out), 0);

    // Load S=1 and V_diag=5 while inactive, then one matching active cycle.
    rst = 1'b0; stall = 1'b0;
    T_in = 2'd0; S_in = 2'd1; store_S_in = 1'b1; init_in = 1'b0;
    V_in = 12'sd5; F_in = 12'sd0; init_V = 12'sd0; init_E = 12'sd0;
    cyc();
    store_S_in = 1'b0; V_in = 12'sd0; F_in = 12'sd0; T_in = 2'd1; init_in = 1'b1;
    cyc();
    check("basic_V", int'(V_out), 7);
    check("basic_E", int'(E_out), -1);
    check("basic_F", int'(F_out), -1);

    // Saturation at both ends.
    init_in = 1'b0; cfg_match = 12'sd5; V_in = 12'sd2046;
    init_V = -12'sd2048; init_E = -12'sd2048;
    cyc();
    check("load_V", int'(V_out), -2048);
    init_in = 1'b1; T_in = 2'd1; V_in = -12'sd2048; F_in = -12'sd2048;
    cyc();
    check("sat_V", int'(V_out), 2047);
    check("sat_E", int'(E_out), -2048);
    check("sat_F", int'(F_out), -2048);

    // Mismatch with every candidate negative floors V at 0.
    init_in = 1'b0; cfg_match = 12'sd2; init_V = -12'sd100; init_E = -12'sd100; V_in = -12'sd50;
    cyc();
    init_in = 1'b1; T_in = 2'd0; V_in = -12'sd10; F_in = -12'sd10;
    cyc();
    check("neg_V", int'(V_out), 0);
    check("neg_E", int'(E_out), -101);
    check("neg_F", int'(F_out), -11);

    // Reset in the middle of a pass.
    rst = 1'b1; init_in = 1'b0;
    cyc();
    check("midrst_V", int'(V_out), 0);
    rst = 1'b0;

    // Max-tracking pass: newV = 3,7,7,4 with a 3-cycle stall inside.
    cfg_match = 12'sd0; cfg_mismatch = 12'sd0; cfg_gap_open = -12'sd10; cfg_gap_ext = -12'sd10;
    init_in = 1'b0; V_in = 12'sd3; F_in = -12'sd100; init_V = 12'sd0; init_E = 12'sd0;
    cyc();
    init_in = 1'b1; V_in = 12'sd7;
    cyc();
    check("p1_V0", int'(V_out), 3);
    V_in = 12'sd7;
    cyc();
    check("p1_V1", int'(V_out), 7);
    stall = 1'b1; V_in = 12'sd100; F_in = 12'sd50; T_in = 2'd2;
    repeat (3) cyc();
    check("stall_V", int'(V_out), 7);
    check("stall_T", int'(T_out), 0);
    check("stall_max", int'(max_out), MT ? 7 : 0);
    stall = 1'b0; F_in = -12'sd100; V_in = 12'sd4;
    cyc();
    V_in = 12'sd0;
    cyc();
    check("p1_V3", int'(V_out), 4);
    init_in = 1'b0; V_in = 12'sd2;
    cyc();
    check("p1_max", int'(max_out), MT ? 7 : 0);
    check("p1_pos", int'(max_pos_out), MT ? 1 : 0);
    cyc();
    check("p1_max_hold", int'(max_out), MT ? 7 : 0);
    check("p1_pos_hold", int'(max_pos_out), MT ? 1 : 0);

    // Second pass restarts tracking from its own first value.
    init_in = 1'b1; V_in = 12'sd0;
    cyc();
    check("p2_V", int'(V_out), 2);
    check("p2_max", int'(max_out), MT ? 2 : 0);
    check("p2_pos", int'(max_pos_out), 0);
    init_in = 1'b0;
    cyc();
    check("p2_max_hold", int'(max_out), MT ? 2 : 0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
